// File: rtl/conv_pkg.sv
// Shared constants, bank-select codes and responder FSM state encoding
// for the CONV engine memory responder.
package conv_pkg;

    // Default pixel width (signed Q4.16, stored verbatim) and image/L0 address width
    localparam int CONV_DW = 20;
    localparam int CONV_AW = 12;

    // Bank select codes shared by csel and host_rsel
    localparam logic [2:0] CSEL_IMG  = 3'd0;
    localparam logic [2:0] CSEL_L0K0 = 3'd1;
    localparam logic [2:0] CSEL_L0K1 = 3'd2;
    localparam logic [2:0] CSEL_L1K0 = 3'd3;
    localparam logic [2:0] CSEL_L1K1 = 3'd4;

    // Start handshake states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // True for the two L1 (quarter-size) bank codes
    function automatic logic isL1Sel(input logic [2:0] sel);
        return (sel == CSEL_L1K0) || (sel == CSEL_L1K1);
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Depth-parameterised RAM: one synchronous write port, two asynchronous
// read ports (engine side and host side). Contents are never cleared.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; reads see the pre-edge contents, giving read-before-write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image RAM with registered read,
// layer banks L0/L1 (kernel-1 banks optional), start handshake FSM with
// watchdog, and a host port for image load and result readback.
module conv_mem_responder
    import conv_pkg::*;
#(
    parameter int DW    = CONV_DW,
    parameter int AW    = CONV_AW,
    parameter int EN_K1 = 0,
    parameter int WDOG  = 1 << 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_start,
    input  logic [2:0]    host_rsel,
    output logic [DW-1:0] host_rdata,
    output logic          done,
    output logic          err,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel
);

    localparam int L1AW = AW - 2;
    localparam int WCW  = $clog2(WDOG + 1);

    state_e          state_q, state_d;
    logic [WCW-1:0]  wdogCnt_q, wdogCnt_d;
    logic            err_q, err_d;
    logic [DW-1:0]   idata_q;
    logic            wdogFire;

    logic            selL0K0, selL0K1, selL1K0, selL1K1, selValid, l1OutOfRange;
    logic            imgWe;
    logic [DW-1:0]   imgRdEng, imgRdHost;
    logic [DW-1:0]   l0k0RdEng, l0k0RdHost, l1k0RdEng, l1k0RdHost;
    logic [DW-1:0]   l0k1RdEng, l0k1RdHost, l1k1RdEng, l1k1RdHost;

    // Engine-side bank decode; kernel-1 codes only count when those banks exist
    always_comb begin
        selL0K0      = (csel == CSEL_L0K0);
        selL1K0      = (csel == CSEL_L1K0);
        selL0K1      = (EN_K1 != 0) && (csel == CSEL_L0K1);
        selL1K1      = (EN_K1 != 0) && (csel == CSEL_L1K1);
        selValid     = selL0K0 | selL1K0 | selL0K1 | selL1K1;
        l1OutOfRange = isL1Sel(csel) && (caddr_wr[AW-1:L1AW] != 2'b00);
    end

    // Host owns the image only while the engine is not running
    assign imgWe = host_we && ((state_q == S_IDLE) || (state_q == S_DONE));

    conv_bank_ram #(.DEPTH(1 << AW), .DW(DW), .AW(AW)) uImg (
        .clk_i(clk), .we_i(imgWe), .waddr_i(host_addr), .wdata_i(host_wdata),
        .raddr_a_i(iaddr), .rdata_a_o(imgRdEng),
        .raddr_b_i(host_addr), .rdata_b_o(imgRdHost)
    );

    conv_bank_ram #(.DEPTH(1 << AW), .DW(DW), .AW(AW)) uL0K0 (
        .clk_i(clk), .we_i(cwr && selL0K0), .waddr_i(caddr_wr), .wdata_i(cdata_wr),
        .raddr_a_i(caddr_rd), .rdata_a_o(l0k0RdEng),
        .raddr_b_i(host_addr), .rdata_b_o(l0k0RdHost)
    );

    conv_bank_ram #(.DEPTH(1 << L1AW), .DW(DW), .AW(L1AW)) uL1K0 (
        .clk_i(clk), .we_i(cwr && selL1K0 && !l1OutOfRange),
        .waddr_i(caddr_wr[L1AW-1:0]), .wdata_i(cdata_wr),
        .raddr_a_i(caddr_rd[L1AW-1:0]), .rdata_a_o(l1k0RdEng),
        .raddr_b_i(host_addr[L1AW-1:0]), .rdata_b_o(l1k0RdHost)
    );

    generate
        if (EN_K1 != 0) begin : gK1
            conv_bank_ram #(.DEPTH(1 << AW), .DW(DW), .AW(AW)) uL0K1 (
                .clk_i(clk), .we_i(cwr && selL0K1), .waddr_i(caddr_wr), .wdata_i(cdata_wr),
                .raddr_a_i(caddr_rd), .rdata_a_o(l0k1RdEng),
                .raddr_b_i(host_addr), .rdata_b_o(l0k1RdHost)
            );
            conv_bank_ram #(.DEPTH(1 << L1AW), .DW(DW), .AW(L1AW)) uL1K1 (
                .clk_i(clk), .we_i(cwr && selL1K1 && !l1OutOfRange),
                .waddr_i(caddr_wr[L1AW-1:0]), .wdata_i(cdata_wr),
                .raddr_a_i(caddr_rd[L1AW-1:0]), .rdata_a_o(l1k1RdEng),
                .raddr_b_i(host_addr[L1AW-1:0]), .rdata_b_o(l1k1RdHost)
            );
        end else begin : gNoK1
            assign l0k1RdEng  = '0;
            assign l0k1RdHost = '0;
            assign l1k1RdEng  = '0;
            assign l1k1RdHost = '0;
        end
    endgenerate

    // Zero-latency engine read mux; disabled or unselected reads return zero
    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (selL0K0)      cdata_rd = l0k0RdEng;
            else if (selL0K1) cdata_rd = l0k1RdEng;
            else if (selL1K0) cdata_rd = l1k0RdEng;
            else if (selL1K1) cdata_rd = l1k1RdEng;
        end
    end

    // Host readback mux, valid in every state; code 0 is the image
    always_comb begin
        host_rdata = '0;
        case (host_rsel)
            CSEL_IMG:  host_rdata = imgRdHost;
            CSEL_L0K0: host_rdata = l0k0RdHost;
            CSEL_L0K1: host_rdata = l0k1RdHost;
            CSEL_L1K0: host_rdata = l1k0RdHost;
            CSEL_L1K1: host_rdata = l1k1RdHost;
            default:   host_rdata = '0;
        endcase
    end

    // Handshake next-state, watchdog count and sticky error accumulation
    always_comb begin
        state_d   = state_q;
        wdogCnt_d = '0;
        ready     = 1'b0;
        done      = 1'b0;
        wdogFire  = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (host_start) state_d = S_REQ;
            end
            S_REQ: begin
                ready = 1'b1;
                if (busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (!busy) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (host_start) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_REQ) || (state_q == S_RUN)) begin
            if (wdogCnt_q == WCW'(WDOG - 1)) begin
                wdogFire = 1'b1;
                state_d  = S_DONE;
            end else begin
                wdogCnt_d = wdogCnt_q + 1'b1;
            end
        end

        if (wdogFire)                           err_d = 1'b1;
        if ((cwr || crd) && !selValid)          err_d = 1'b1;
        if (cwr && l1OutOfRange)                err_d = 1'b1;
    end

    // State, watchdog and error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wdogCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdogCnt_q <= wdogCnt_d;
            err_q     <= err_d;
        end
    end

    // Registered image read: one cycle from iaddr to idata
    always_ff @(posedge clk) begin
        if (reset) begin
            idata_q <= '0;
        end else begin
            idata_q <= imgRdEng;
        end
    end

    assign idata = idata_q;
    assign err   = err_q;

endmodule
